// File: rtl/axi4lite_host_mailbox_if.sv
// AXI4-Lite channel bundle for the host mailbox; master drives requests, slave responds.
interface axi4lite_host_mailbox_if;
  logic        awvalid;
  logic        awready;
  logic [31:0] awaddr;
  logic [2:0]  awprot;
  logic [3:0]  awcache;
  logic        wvalid;
  logic        wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        bvalid;
  logic        bready;
  logic [1:0]  bresp;
  logic        arvalid;
  logic        arready;
  logic [31:0] araddr;
  logic [2:0]  arprot;
  logic [3:0]  arcache;
  logic        rvalid;
  logic        rready;
  logic [1:0]  rresp;
  logic [31:0] rdata;

  modport master (
    output awvalid, awaddr, awprot, awcache, input awready,
    output wvalid, wdata, wstrb, input wready,
    input bvalid, bresp, output bready,
    output arvalid, araddr, arprot, arcache, input arready,
    input rvalid, rresp, rdata, output rready
  );

  modport slave (
    input awvalid, awaddr, awprot, awcache, output awready,
    input wvalid, wdata, wstrb, output wready,
    output bvalid, bresp, input bready,
    input arvalid, araddr, arprot, arcache, output arready,
    output rvalid, rresp, rdata, input rready
  );
endinterface

// File: rtl/axi4lite_host_mailbox.sv
// Host mailbox on AXI4-Lite: TOHOST/FROMHOST registers, free-running cycle
// counter and a sticky completion status derived from TOHOST writes.
module axi4lite_host_mailbox #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_6000
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  axi4lite_host_mailbox_if.slave bus,
  input  logic                   host_fromhost_valid,
  input  logic [31:0]            host_fromhost_data,
  output logic                   done,
  output logic                   pass,
  output logic [30:0]            exit_code
);

  typedef enum logic [1:0] {
    REG_TOHOST   = 2'd0,
    REG_FROMHOST = 2'd1,
    REG_CYCLES   = 2'd2,
    REG_STATUS   = 2'd3
  } reg_sel_e;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10
  } resp_e;

  logic        live_q, live_d;
  logic        aw_full_q, aw_full_d;
  logic [31:2] aw_addr_q, aw_addr_d;
  logic        w_full_q, w_full_d;
  logic [31:0] w_data_q, w_data_d;
  logic [3:0]  w_strb_q, w_strb_d;
  logic        bvalid_q, bvalid_d;
  logic [1:0]  bresp_q, bresp_d;
  logic        rvalid_q, rvalid_d;
  logic [1:0]  rresp_q, rresp_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] tohost_q, tohost_d;
  logic [31:0] fromhost_q, fromhost_d;
  logic [31:0] cycles_q, cycles_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;
  logic [30:0] exit_code_q, exit_code_d;

  logic        aw_ready, w_ready, ar_ready;
  logic        wr_exec, wr_hit, rd_hit;
  reg_sel_e    wr_sel, rd_sel;
  logic [31:0] wr_old, wr_merged, rd_val;
  logic        unused_bits;

  // Readies come only from flops; live_q keeps them low until the first edge after reset.
  assign aw_ready    = live_q & ~aw_full_q;
  assign w_ready     = live_q & ~w_full_q;
  assign ar_ready    = live_q & ~rvalid_q;

  assign bus.awready = aw_ready;
  assign bus.wready  = w_ready;
  assign bus.arready = ar_ready;
  assign bus.bvalid  = bvalid_q;
  assign bus.bresp   = bresp_q;
  assign bus.rvalid  = rvalid_q;
  assign bus.rresp   = rresp_q;
  assign bus.rdata   = rdata_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign exit_code   = exit_code_q;

  assign unused_bits = ^{bus.awprot, bus.awcache, bus.arprot, bus.arcache,
                         bus.awaddr[1:0], bus.araddr[1:0]};

  // Next-state for holding slots, write/read channels, mailbox registers and status.
  always_comb begin
    live_d      = 1'b1;
    aw_full_d   = aw_full_q;
    aw_addr_d   = aw_addr_q;
    w_full_d    = w_full_q;
    w_data_d    = w_data_q;
    w_strb_d    = w_strb_q;
    bvalid_d    = bvalid_q;
    bresp_d     = bresp_q;
    rvalid_d    = rvalid_q;
    rresp_d     = rresp_q;
    rdata_d     = rdata_q;
    tohost_d    = tohost_q;
    fromhost_d  = fromhost_q;
    cycles_d    = cycles_q + 32'd1;
    done_d      = done_q;
    pass_d      = pass_q;
    exit_code_d = exit_code_q;

    wr_exec   = aw_full_q & w_full_q & ~bvalid_q;
    wr_hit    = (aw_addr_q[31:4] == BASE_ADDR[31:4]);
    wr_sel    = reg_sel_e'(aw_addr_q[3:2]);
    wr_old    = (wr_sel == REG_TOHOST) ? tohost_q : fromhost_q;
    wr_merged = wr_old;
    for (int unsigned i = 0; i < 4; i++) begin
      if (w_strb_q[i]) wr_merged[8*i +: 8] = w_data_q[8*i +: 8];
    end

    rd_hit = (bus.araddr[31:4] == BASE_ADDR[31:4]);
    rd_sel = reg_sel_e'(bus.araddr[3:2]);
    rd_val = '0;
    unique case (rd_sel)
      REG_TOHOST:   rd_val = tohost_q;
      REG_FROMHOST: rd_val = fromhost_q;
      REG_CYCLES:   rd_val = cycles_q;
      REG_STATUS:   rd_val = {30'b0, pass_q, done_q};
    endcase

    if (bus.awvalid && aw_ready) begin
      aw_full_d = 1'b1;
      aw_addr_d = bus.awaddr[31:2];
    end
    if (bus.wvalid && w_ready) begin
      w_full_d = 1'b1;
      w_data_d = bus.wdata;
      w_strb_d = bus.wstrb;
    end

    if (bvalid_q && bus.bready) bvalid_d = 1'b0;

    if (wr_exec) begin
      aw_full_d = 1'b0;
      w_full_d  = 1'b0;
      bvalid_d  = 1'b1;
      if (wr_hit && (wr_sel == REG_TOHOST || wr_sel == REG_FROMHOST)) begin
        bresp_d = RESP_OKAY;
        if (wr_sel == REG_TOHOST) begin
          tohost_d = wr_merged;
          if (!done_q && wr_merged[0]) begin
            done_d      = 1'b1;
            pass_d      = (wr_merged == 32'h1);
            exit_code_d = wr_merged[31:1];
          end
        end else begin
          fromhost_d = wr_merged;
        end
      end else begin
        bresp_d = RESP_SLVERR;
      end
    end

    // Host load overrides any bus write to FROMHOST in the same cycle.
    if (host_fromhost_valid) fromhost_d = host_fromhost_data;

    if (rvalid_q && bus.rready) rvalid_d = 1'b0;

    // Read samples the current register values, so a same-cycle write is not visible.
    if (bus.arvalid && ar_ready) begin
      rvalid_d = 1'b1;
      if (rd_hit) begin
        rdata_d = rd_val;
        rresp_d = RESP_OKAY;
      end else begin
        rdata_d = '0;
        rresp_d = RESP_SLVERR;
      end
    end
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      live_q      <= 1'b0;
      aw_full_q   <= 1'b0;
      aw_addr_q   <= '0;
      w_full_q    <= 1'b0;
      w_data_q    <= '0;
      w_strb_q    <= '0;
      bvalid_q    <= 1'b0;
      bresp_q     <= '0;
      rvalid_q    <= 1'b0;
      rresp_q     <= '0;
      rdata_q     <= '0;
      tohost_q    <= '0;
      fromhost_q  <= '0;
      cycles_q    <= '0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      exit_code_q <= '0;
    end else begin
      live_q      <= live_d;
      aw_full_q   <= aw_full_d;
      aw_addr_q   <= aw_addr_d;
      w_full_q    <= w_full_d;
      w_data_q    <= w_data_d;
      w_strb_q    <= w_strb_d;
      bvalid_q    <= bvalid_d;
      bresp_q     <= bresp_d;
      rvalid_q    <= rvalid_d;
      rresp_q     <= rresp_d;
      rdata_q     <= rdata_d;
      tohost_q    <= tohost_d;
      fromhost_q  <= fromhost_d;
      cycles_q    <= cycles_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      exit_code_q <= exit_code_d;
    end
  end

endmodule

// File: tb/tb_axi4lite_host_mailbox.sv
// Directed bench for the AXI4-Lite host mailbox: register table plus
// hand-timed sequences for channel overlap, back-pressure and reset.
module tb_axi4lite_host_mailbox;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        host_fromhost_valid = 1'b0;
  logic [31:0] host_fromhost_data = '0;
  logic        done, pass;
  logic [30:0] exit_code;
  int          tb_cyc = 0;
  int          n_cmp = 0;
  int          n_err = 0;

  axi4lite_host_mailbox_if m ();

  axi4lite_host_mailbox #(.BASE_ADDR(32'h0000_6000)) dut (
    .aclk                (aclk),
    .aresetn             (aresetn),
    .bus                 (m),
    .host_fromhost_valid (host_fromhost_valid),
    .host_fromhost_data  (host_fromhost_data),
    .done                (done),
    .pass                (pass),
    .exit_code           (exit_code)
  );

  always #5 aclk = ~aclk;
  always @(posedge aclk) tb_cyc <= tb_cyc + 1;

  typedef struct {
    bit          is_wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  exp_resp;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: handshake did not complete within bound", name);
  endtask

  // Order 0: AW and W together; 1: AW first; 2: W first. gap = cycles between.
  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int order, input int gap, output logic [1:0] resp);
    bit aw_done, w_done, aw_hs, w_hs;
    int g;
    aw_done = 0; w_done = 0; g = 0;
    resp = 2'bxx;
    m.awaddr = addr; m.wdata = data; m.wstrb = strb;
    m.awvalid = (order != 2);
    m.wvalid  = (order != 1);
    for (int i = 0; i < 100 && !(aw_done && w_done); i++) begin
      aw_hs = m.awvalid && m.awready;
      w_hs  = m.wvalid && m.wready;
      @(posedge aclk); #1;
      if (aw_hs) begin m.awvalid = 1'b0; aw_done = 1; end
      if (w_hs)  begin m.wvalid  = 1'b0; w_done  = 1; end
      if ((aw_done && !w_done && !m.wvalid) || (w_done && !aw_done && !m.awvalid)) begin
        if (g >= gap) begin
          if (!aw_done) m.awvalid = 1'b1;
          else          m.wvalid  = 1'b1;
        end
        g++;
      end
    end
    if (!(aw_done && w_done)) begin
      m.awvalid = 1'b0; m.wvalid = 1'b0;
      timeout("wr_addr_data");
      return;
    end
    for (int i = 0; i < 20 && !m.bvalid; i++) begin @(posedge aclk); #1; end
    if (!m.bvalid) begin
      timeout("wr_bvalid");
      return;
    end
    resp = m.bresp;
    m.bready = 1'b1;
    @(posedge aclk); #1;
    m.bready = 1'b0;
  endtask

  task automatic axi_read(input logic [31:0] addr, output logic [31:0] data,
                          output logic [1:0] resp, output int hs);
    data = 'x; resp = 'x; hs = 0;
    m.araddr = addr; m.arvalid = 1'b1;
    for (int i = 0; i < 50 && !m.arready; i++) begin @(posedge aclk); #1; end
    if (!m.arready) begin
      m.arvalid = 1'b0;
      timeout("rd_arready");
      return;
    end
    @(posedge aclk); #1;
    hs = tb_cyc;
    m.arvalid = 1'b0;
    for (int i = 0; i < 50 && !m.rvalid; i++) begin @(posedge aclk); #1; end
    if (!m.rvalid) begin
      timeout("rd_rvalid");
      return;
    end
    data = m.rdata; resp = m.rresp;
    m.rready = 1'b1;
    @(posedge aclk); #1;
    m.rready = 1'b0;
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    repeat (2) @(posedge aclk);
    #4 aresetn = 1'b1;
    @(posedge aclk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [1:0]  resp;
    logic [31:0] rd, d1, d2;
    int          c1, c2, hs;

    m.awvalid = 0; m.awaddr = '0; m.awprot = '0; m.awcache = '0;
    m.wvalid = 0; m.wdata = '0; m.wstrb = '0; m.bready = 0;
    m.arvalid = 0; m.araddr = '0; m.arprot = '0; m.arcache = '0; m.rready = 0;

    vecs[0]  = '{1'b1, 32'h6000, 32'h1234_5678, 4'hF, 2'b00, 32'h0};
    vecs[1]  = '{1'b0, 32'h6000, 32'h0,         4'h0, 2'b00, 32'h1234_5678};
    vecs[2]  = '{1'b1, 32'h6000, 32'hAABB_CCDE, 4'h5, 2'b00, 32'h0};
    vecs[3]  = '{1'b0, 32'h6000, 32'h0,         4'h0, 2'b00, 32'h12BB_56DE};
    vecs[4]  = '{1'b1, 32'h6004, 32'hCAFE_F00D, 4'hF, 2'b00, 32'h0};
    vecs[5]  = '{1'b1, 32'h6004, 32'hFFFF_FFFF, 4'h0, 2'b00, 32'h0};
    vecs[6]  = '{1'b0, 32'h6006, 32'h0,         4'h0, 2'b00, 32'hCAFE_F00D};
    vecs[7]  = '{1'b1, 32'h6008, 32'h5,         4'hF, 2'b10, 32'h0};
    vecs[8]  = '{1'b1, 32'h600C, 32'h3,         4'hF, 2'b10, 32'h0};
    vecs[9]  = '{1'b1, 32'h7000, 32'h1,         4'hF, 2'b10, 32'h0};
    vecs[10] = '{1'b0, 32'h600C, 32'h0,         4'h0, 2'b00, 32'h0};
    vecs[11] = '{1'b0, 32'h7000, 32'h0,         4'h0, 2'b10, 32'h0};
    vecs[12] = '{1'b0, 32'h5FFC, 32'h0,         4'h0, 2'b10, 32'h0};
    vecs[13] = '{1'b1, 32'h6003, 32'h0000_0100, 4'h2, 2'b00, 32'h0};
    vecs[14] = '{1'b0, 32'h6000, 32'h0,         4'h0, 2'b00, 32'h12BB_01DE};
    vecs[15] = '{1'b0, 32'h6004, 32'h0,         4'h0, 2'b00, 32'hCAFE_F00D};

    // Reset values while aresetn is low
    #2;
    chk("rst_awready", {31'b0, m.awready}, 32'h0);
    chk("rst_wready",  {31'b0, m.wready},  32'h0);
    chk("rst_arready", {31'b0, m.arready}, 32'h0);
    chk("rst_bvalid",  {31'b0, m.bvalid},  32'h0);
    chk("rst_rvalid",  {31'b0, m.rvalid},  32'h0);
    chk("rst_rdata",   m.rdata, 32'h0);
    chk("rst_status",  {30'b0, pass, done}, 32'h0);
    chk("rst_exit",    {1'b0, exit_code}, 32'h0);
    repeat (2) @(posedge aclk);
    #4 aresetn = 1'b1;
    @(posedge aclk); #1;
    chk("post_rst_readies", {29'b0, m.awready, m.wready, m.arready}, 32'h7);

    // Register table
    for (int i = 0; i < 16; i++) begin
      if (vecs[i].is_wr) begin
        axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, i % 3, 1, resp);
        chk($sformatf("vec%0d_bresp", i), {30'b0, resp}, {30'b0, vecs[i].exp_resp});
      end else begin
        axi_read(vecs[i].addr, rd, resp, hs);
        chk($sformatf("vec%0d_rresp", i), {30'b0, resp}, {30'b0, vecs[i].exp_resp});
        chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
      end
    end
    chk("table_not_done", {31'b0, done}, 32'h0);

    // Host load collides with bus write of 0 to FROMHOST: host value survives
    m.awaddr = 32'h6004; m.wdata = 32'h0; m.wstrb = 4'hF;
    m.awvalid = 1'b1; m.wvalid = 1'b1;
    @(posedge aclk); #1;
    m.awvalid = 1'b0; m.wvalid = 1'b0;
    host_fromhost_valid = 1'b1; host_fromhost_data = 32'hA5A5_A5A5;
    @(posedge aclk); #1;
    host_fromhost_valid = 1'b0;
    chk("host_win_bvalid", {31'b0, m.bvalid}, 32'h1);
    chk("host_win_bresp", {30'b0, m.bresp}, 32'h0);
    m.bready = 1'b1; @(posedge aclk); #1; m.bready = 1'b0;
    axi_read(32'h6004, rd, resp, hs);
    chk("host_win_rdata", rd, 32'hA5A5_A5A5);

    // B back-pressure: second write waits in the slots until B handshake
    m.awaddr = 32'h6004; m.wdata = 32'h11; m.wstrb = 4'hF;
    m.awvalid = 1'b1; m.wvalid = 1'b1;
    @(posedge aclk); #1;
    m.wdata = 32'h22;
    @(posedge aclk); #1;
    @(posedge aclk); #1;
    m.awvalid = 1'b0; m.wvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp%0d_bvalid", i), {31'b0, m.bvalid}, 32'h1);
      chk($sformatf("bp%0d_bresp", i), {30'b0, m.bresp}, 32'h0);
      chk($sformatf("bp%0d_slots_full", i), {30'b0, m.awready, m.wready}, 32'h0);
      @(posedge aclk); #1;
    end
    axi_read(32'h6004, rd, resp, hs);
    chk("bp_first_only", rd, 32'h11);
    chk("bp_still_bvalid", {31'b0, m.bvalid}, 32'h1);
    m.bready = 1'b1; @(posedge aclk); #1; m.bready = 1'b0;
    chk("bp_b_taken", {31'b0, m.bvalid}, 32'h0);
    @(posedge aclk); #1;
    chk("bp_second_bvalid", {31'b0, m.bvalid}, 32'h1);
    chk("bp_slots_free", {30'b0, m.awready, m.wready}, 32'h3);
    m.bready = 1'b1; @(posedge aclk); #1; m.bready = 1'b0;
    axi_read(32'h6004, rd, resp, hs);
    chk("bp_second_data", rd, 32'h22);

    // Read and write of TOHOST in the same cycle: read sees old value
    m.awaddr = 32'h6000; m.wdata = 32'h44; m.wstrb = 4'hF;
    m.awvalid = 1'b1; m.wvalid = 1'b1;
    @(posedge aclk); #1;
    m.awvalid = 1'b0; m.wvalid = 1'b0;
    m.araddr = 32'h6000; m.arvalid = 1'b1;
    @(posedge aclk); #1;
    m.arvalid = 1'b0;
    chk("rw_same_bvalid", {31'b0, m.bvalid}, 32'h1);
    chk("rw_same_rvalid", {31'b0, m.rvalid}, 32'h1);
    chk("rw_same_old", m.rdata, 32'h12BB_01DE);
    m.bready = 1'b1; m.rready = 1'b1;
    @(posedge aclk); #1;
    m.bready = 1'b0; m.rready = 1'b0;
    axi_read(32'h6000, rd, resp, hs);
    chk("rw_same_new", rd, 32'h44);

    // CYCLES advances one per clock
    axi_read(32'h6008, d1, resp, c1);
    repeat (7) @(posedge aclk);
    #1;
    axi_read(32'h6008, d2, resp, c2);
    chk("cycles_delta", d2 - d1, c2 - c1);

    // Reset in the middle of a read
    m.araddr = 32'h6008; m.arvalid = 1'b1;
    @(posedge aclk); #1;
    m.arvalid = 1'b0;
    chk("midrst_rvalid_up", {31'b0, m.rvalid}, 32'h1);
    #2 aresetn = 1'b0;
    #1;
    chk("midrst_rvalid_drop", {31'b0, m.rvalid}, 32'h0);
    chk("midrst_arready", {31'b0, m.arready}, 32'h0);
    @(posedge aclk);
    @(negedge aclk);
    aresetn = 1'b1;
    @(posedge aclk); #1;
    chk("midrst_no_resp", {31'b0, m.rvalid}, 32'h0);
    chk("midrst_readies", {29'b0, m.awready, m.wready, m.arready}, 32'h7);
    m.araddr = 32'h6008; m.arvalid = 1'b1; m.rready = 1'b1;
    @(posedge aclk); #1;
    m.arvalid = 1'b0;
    // CYCLES was 0 at release, 1 at the edge that accepted the read
    chk("midrst_cycles", m.rdata, 32'h1);
    @(posedge aclk); #1;
    m.rready = 1'b0;
    axi_read(32'h6004, rd, resp, hs);
    chk("midrst_fromhost_clr", rd, 32'h0);

    // Passing completion: AW then W three cycles later
    do_reset();
    axi_write(32'h6000, 32'h1, 4'hF, 1, 3, resp);
    chk("pass_bresp", {30'b0, resp}, 32'h0);
    chk("pass_status", {30'b0, pass, done}, 32'h3);
    chk("pass_exit", {1'b0, exit_code}, 32'h0);
    axi_read(32'h600C, rd, resp, hs);
    chk("pass_status_reg", rd, 32'h3);

    // Failing completion: W before AW, then completion is sticky
    do_reset();
    axi_write(32'h6000, 32'h0000_000B, 4'hF, 2, 2, resp);
    chk("fail_bresp", {30'b0, resp}, 32'h0);
    chk("fail_status", {30'b0, pass, done}, 32'h1);
    chk("fail_exit", {1'b0, exit_code}, 32'h5);
    axi_write(32'h6000, 32'h1, 4'hF, 0, 0, resp);
    chk("sticky_bresp", {30'b0, resp}, 32'h0);
    chk("sticky_status", {30'b0, pass, done}, 32'h1);
    chk("sticky_exit", {1'b0, exit_code}, 32'h5);
    axi_read(32'h6000, rd, resp, hs);
    chk("sticky_tohost", rd, 32'h1);
    axi_read(32'h600C, rd, resp, hs);
    chk("sticky_status_reg", rd, 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/axi4lite_host_mailbox.md
AXI4LITE_HOST_MAILBOX -- requirements
Module: axi4lite_host_mailbox

Interface
REQ-001 Parameter BASE_ADDR, default 32'h00006000, 16-byte aligned base of the register window.
REQ-002 aclk  in  1  sole clock; all logic is rising-edge.
REQ-003 aresetn  in  1  asynchronous, active-low reset.
REQ-004 awvalid/awready  in/out  1/1; awaddr in 32; awprot in 3; awcache in 4 (prot and cache ignored).
REQ-005 wvalid/wready  in/out  1/1; wdata in 32; wstrb in 4.
REQ-006 bvalid out 1; bready in 1; bresp out 2.
REQ-007 arvalid/arready  in/out  1/1; araddr in 32; arprot in 3; arcache in 4 (prot and cache ignored).
REQ-008 rvalid out 1; rready in 1; rresp out 2; rdata out 32.
REQ-009 host_fromhost_valid  in  1  single-cycle load strobe for FROMHOST.
REQ-010 host_fromhost_data  in  32  value loaded into FROMHOST.
REQ-011 done  out  1  sticky; test has reported completion.
REQ-012 pass  out  1  valid when done; 1 = success.
REQ-013 exit_code  out  31  TOHOST[31:1] captured at completion.

Function
REQ-014 Decode: hit when addr[31:4]==BASE_ADDR[31:4]; offset addr[3:2]; addr[1:0] ignored.
REQ-015 Map: 0x0 TOHOST RW; 0x4 FROMHOST RW; 0x8 CYCLES RO; 0xC STATUS RO = {30'b0, pass, done}.
REQ-016 AW and W accepted independently, each into a one-entry holding register; awready=1 iff AW slot empty; wready=1 iff W slot empty.
REQ-017 Write executes in the cycle both slots are full and bvalid is 0; both slots free that cycle; bvalid rises next cycle.
REQ-018 Write applies wstrb per byte; wstrb=0 is a legal no-op with OKAY.
REQ-019 bresp: 2'b00 OKAY for hit on TOHOST/FROMHOST; 2'b10 SLVERR for miss or offset 0x8/0xC (no state change).
REQ-020 bvalid, bresp held stable until bready; slots refill only after the B handshake frees the write path (no second write executes while bvalid=1).
REQ-021 arready = ~rvalid; AR handshake latches rdata/rresp, rvalid rises next cycle, held stable until rready.
REQ-022 Read miss: rdata=0, rresp=2'b10; hit: rresp=2'b00.
REQ-023 Read and write executing same cycle to same register: read returns pre-write value.
REQ-024 Completion: write executing to TOHOST whose post-strobe value has bit0=1 sets done=1, pass=(value==32'h1), exit_code=value[31:1]; later writes do not alter done/pass/exit_code.
REQ-025 TOHOST writes with bit0=0 update TOHOST only.
REQ-026 host_fromhost_valid loads FROMHOST; simultaneous bus write to FROMHOST is dropped (host wins), bus still gets OKAY.
REQ-027 CYCLES increments every cycle out of reset, wraps 32'hFFFFFFFF->0.
REQ-028 No combinational path from any *valid/*ready input to any *ready/*valid output.

Reset
REQ-029 aresetn low asynchronously clears: awready, wready, arready =0 while in reset; bvalid, rvalid, done, pass =0; bresp, rresp, rdata, exit_code =0; all registers, holding slots =0.
REQ-030 First cycle after release: awready=wready=arready=1.
REQ-031 Reset mid-transaction discards held AW/W and pending B/R; no response is issued for them.

Verification
REQ-032 AW then W three cycles later, addr 0x6000, data 1, strb F -> one B OKAY; done=1, pass=1, exit_code=0.
REQ-033 W before AW, addr 0x6000, data 32'h0000000B -> done=1, pass=0, exit_code=5; later write of 1 leaves pass=0.
REQ-034 Write 0x7000 and read 0x600C -> bresp=2'b10, no state change; read 0x7000 -> rdata=0, rresp=2'b10.
REQ-035 bready held low 5 cycles after write -> bvalid/bresp stable, awready/wready stay 0 after slots fill; second write completes only after B handshake.
REQ-036 host_fromhost_valid with data 32'hA5A5A5A5 same cycle as bus write of 0 to 0x6004 -> read 0x6004 returns 32'hA5A5A5A5.
REQ-037 Read 0x6008 twice N cycles apart -> difference N; aresetn pulsed mid-read -> rvalid drops immediately, CYCLES restarts at 0.
